// File: rtl/counter_pkg.sv
// Shared definitions for the counter/timer family: counting mode enum.
package counter_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

endpackage

// File: rtl/counter_ext_if.sv
// Control/status bundle for counter_ext; master drives controls, slave is the counter.
interface counter_ext_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  import counter_pkg::*;

  logic              en;
  logic              load;
  logic [WIDTH-1:0]  load_value;
  logic              up;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  limit;
  cnt_mode_e         mode;
  logic              flag_clr;
  logic [WIDTH-1:0]  count;
  logic              tc;
  logic              ovf;
  logic              unf;

  modport master (
    output en, load, load_value, up, step, limit, mode, flag_clr,
    input  count, tc, ovf, unf
  );

  modport slave (
    input  en, load, load_value, up, step, limit, mode, flag_clr,
    output count, tc, ovf, unf
  );

endinterface

// File: rtl/counter_prescaler.sv
// Enable prescaler: emits tick on every PRESCALE-th enabled cycle; restart zeroes the phase.
module counter_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tick
);

  generate
    if (PRESCALE == 1) begin : g_pass
      logic unused_ok;
      assign unused_ok = ^{clk, rst, restart};
      assign tick      = en;
    end else begin : g_cnt
      localparam int            PW   = $clog2(PRESCALE);
      localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

      logic [PW-1:0] phase_q, phase_d;

      always_comb begin
        phase_d = phase_q;
        if (restart)
          phase_d = '0;
        else if (en)
          phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
      end

      always_ff @(posedge clk) begin
        if (rst) phase_q <= '0;
        else     phase_q <= phase_d;
      end

      assign tick = en && (phase_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/counter_ext.sv
// Loadable up/down counter with limit, variable step, wrap/saturate and ovf/unf reporting.
// Define COUNTER_STICKY_FLAGS_EN to make ovf/unf sticky until flag_clr.
module counter_ext
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 4,
  parameter int PRESCALE = 1
) (
  input logic           clk,
  input logic           rst,
  counter_ext_if.slave  bus
);

  logic             tick;
  logic             cnt_evt;
  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             ovf_evt, unf_evt;
  logic [WIDTH:0]   cnt_ext, lim_ext, lim_p1, step_ext, s_eff;
  logic [WIDTH:0]   sum_up, wrap_up, wrap_dn;

  counter_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .en      (bus.en),
    .restart (bus.load),
    .tick    (tick)
  );

  assign cnt_evt = bus.en && tick && !bus.load;

  // All range arithmetic is done one bit wider so limit+1 and count+s never overflow.
  always_comb begin
    cnt_ext  = {1'b0, count_q};
    lim_ext  = {1'b0, bus.limit};
    lim_p1   = lim_ext + (WIDTH+1)'(1);
    step_ext = (WIDTH+1)'(bus.step);
    s_eff    = (step_ext > lim_p1) ? lim_p1 : step_ext;
    sum_up   = cnt_ext + s_eff;
    wrap_up  = sum_up - lim_p1;
    wrap_dn  = cnt_ext + lim_p1 - s_eff;

    count_d  = count_q;
    ovf_evt  = 1'b0;
    unf_evt  = 1'b0;

    if (bus.load) begin
      count_d = (bus.load_value > bus.limit) ? bus.limit : bus.load_value;
    end else if (cnt_evt) begin
      if (count_q > bus.limit) begin
        ovf_evt = 1'b1;
        count_d = (bus.mode == CNT_WRAP) ? '0 : bus.limit;
      end else if (s_eff != '0) begin
        if (bus.up) begin
          if (sum_up <= lim_ext) begin
            count_d = sum_up[WIDTH-1:0];
          end else begin
            ovf_evt = 1'b1;
            count_d = (bus.mode == CNT_WRAP) ? wrap_up[WIDTH-1:0] : bus.limit;
          end
        end else begin
          if (s_eff <= cnt_ext) begin
            count_d = count_q - s_eff[WIDTH-1:0];
          end else begin
            unf_evt = 1'b1;
            count_d = (bus.mode == CNT_WRAP) ? wrap_dn[WIDTH-1:0] : '0;
          end
        end
      end
    end
  end

`ifdef COUNTER_STICKY_FLAGS_EN
  // A new event wins over a coincident clear.
  assign ovf_d = (ovf_q && !bus.flag_clr) || ovf_evt;
  assign unf_d = (unf_q && !bus.flag_clr) || unf_evt;
`else
  logic unused_ok;
  assign unused_ok = bus.flag_clr;
  assign ovf_d     = ovf_evt;
  assign unf_d     = unf_evt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.count = count_q;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
  assign bus.tc    = bus.up ? (count_q == bus.limit) : (count_q == '0);

endmodule
